ifetch_prefetch_queue: RTL and testbench
========================================

Name: ifetch_prefetch_queue

Overview:
Halfword prefetch queue directly upstream of the instruction fetcher. It issues aligned 32-bit reads to instruction memory and buffers the returned halfwords in a ring buffer. It presents up to 4 halfwords (64 bits) starting at the current PC to the fetcher, which consumes 1-4 halfwords per cycle according to decoded instruction length. A redirect (branch/jump) flushes the queue and restarts fetch.

Parameters:
DEPTH, 8, ring buffer depth in halfwords; power of 2, >= 4
AW, 25, halfword address width (matches fetcher PC width)
RESET_PC, 0, halfword address fetched first after reset

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
mem_req_o  out  1  memory read request
mem_addr_o  out  AW  halfword address of request; bit 0 always 0
mem_gnt_i  in  1  request accepted this cycle
mem_rvalid_i  in  1  read data valid (one per granted request, in order)
mem_rdata_i  in  32  [15:0] = halfword at addr, [31:16] = halfword at addr+1
inst_o  out  64  [15:0] = halfword at pc_o, [31:16] = pc_o+1, ...; lanes beyond avail_o are zero
pc_o  out  AW  halfword address of inst_o[15:0]
avail_o  out  3  valid halfwords visible, 0-4 (min(count,4))
consume_i  in  3  halfwords consumed this cycle, 0-4
redirect_i  in  1  flush and restart
redirect_pc_i  in  AW  new fetch address (halfword)

Behaviour:
- Reset: mem_req_o=0, mem_addr_o=0, count=0, avail_o=0, inst_o=0, pc_o=RESET_PC, rd/wr pointers=0, no outstanding request, drop flag=0. First request is issued in the first cycle after rst deasserts, to RESET_PC with bit 0 cleared.
- Outputs inst_o/pc_o/avail_o derive from registered state only (no combinational path from inputs).
- Max one outstanding request. New request is raised when: no request pending/outstanding, and count <= DEPTH-2. mem_addr_o = next fetch address with bit 0 cleared.
- mem_req_o and mem_addr_o are held stable until mem_gnt_i. After grant, the request is outstanding until mem_rvalid_i. A grant and rvalid may not coincide for the same request. Zero-wait memory gives one request every 2 cycles.
- On rvalid: write both halfwords at wr_ptr and wr_ptr+1, wrapping mod DEPTH, then count += 2. If fetch started at an odd address (first response after reset/redirect with target bit 0 = 1), write only [31:16], count += 1. Fetch address advances by 2.
- consume_i: rd_ptr += n, pc_o += n (mod 2^AW), count -= n, where n = min(consume_i, avail_o); values > avail_o are clamped.
- Same-cycle write and consume: count_next = count + written - n. The queue never overflows by the issue rule.
- Redirect (highest priority): count=0, rd_ptr=wr_ptr=0, pc_o=redirect_pc_i, fetch address = redirect_pc_i, consume_i ignored, any rvalid in the same cycle is discarded.
  - If a request is outstanding, drop flag=1 and its response is discarded.
  - If a request is pending ungranted, it stays held until granted and is then treated as outstanding with drop=1.
  - The new request issues once nothing is pending/outstanding.
- Redirect at same cycle as rst: rst wins.
- Address wrap: fetch address and pc_o wrap at 2^AW without error.

Optional Feature:
IFQ_BYPASS_EN:
- Defined: when count==0 and rvalid (not dropped), inst_o/avail_o/pc_o show the incoming halfwords in the same cycle. consume_i applies to them, and only unconsumed halfwords are written.
- Undefined: data visible one cycle after rvalid; no combinational rvalid-to-output path.

Test Plan:
- Reset, RESET_PC=0, zero-wait memory, consume_i=0 -> requests to 0,2,4,6 then mem_req_o stays 0; avail_o=4, count=8 (full), inst_o = halfwords 0..3.
- Full queue, consume_i=1 for one cycle -> pc_o=1, avail_o=4. Next request issues only after count <= 6.
- Redirect to 0x00005 with empty queue -> request addr 0x00004. Only the halfword at 5 is enqueued, avail_o=1, pc_o=0x00005.
- Redirect while request outstanding -> the later rvalid is discarded (avail_o stays 0), then request to redirect target; pc_o=target.
- Steady state, consume_i=2 every cycle, zero-wait memory -> no overflow, pc_o increments by 2 while avail_o>=2, and inst_o matches memory contents.
- consume_i=4 with avail_o=2 -> clamped: pc_o += 2, avail_o=0, no pointer corruption on subsequent fills.

Source files
------------

// File: rtl/ifetch_prefetch_queue.sv
// ifetch_prefetch_queue: halfword prefetch ring buffer feeding the instruction fetcher.
// Optional same-cycle bypass of returning data into an empty queue: IFQ_BYPASS_EN.
module ifetch_prefetch_queue #(
  parameter int DEPTH = 8,
  parameter int AW = 25,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [31:0]   mem_rdata_i,
  output logic [63:0]   inst_o,
  output logic [AW-1:0] pc_o,
  output logic [2:0]    avail_o,
  input  logic [2:0]    consume_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [15:0] hw_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [AW-1:0] pc_q, fa_q, fa_n, addr_q;
  logic req_q, out_q, drop_q, odd_q;
  logic acc, byp, inflight_n, issue;
  logic [2:0] w, n, nr, nb, wn, avail;
  logic [15:0] hw_lo, hw_hi;
  always_comb begin
    acc = mem_rvalid_i & ~drop_q & ~redirect_i;
    w = acc ? (odd_q ? 3'd1 : 3'd2) : 3'd0;
`ifdef IFQ_BYPASS_EN
    byp = acc & (cnt_q == '0);
`else
    byp = 1'b0;
`endif
    avail = byp ? w : (cnt_q >= CW'(4) ? 3'd4 : cnt_q[2:0]);
    n = redirect_i ? 3'd0 : (consume_i > avail ? avail : consume_i);
    nr = byp ? 3'd0 : n;
    nb = byp ? n : 3'd0;
    wn = w - nb;
    cnt_n = redirect_i ? '0 : cnt_q + CW'(wn) - CW'(nr);
    fa_n = redirect_i ? redirect_pc_i : acc ? {fa_q[AW-1:1], 1'b0} + AW'(2) : fa_q;
    inflight_n = req_q | (out_q & ~mem_rvalid_i);
    issue = ~inflight_n & (cnt_n <= CW'(DEPTH - 2));
    hw_lo = odd_q ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    hw_hi = mem_rdata_i[31:16];
  end
  always_comb begin
    inst_o = '0;
    for (int i = 0; i < 4; i++)
      if (3'(i) < avail) inst_o[16*i +: 16] = byp ? (i == 0 ? hw_lo : hw_hi) : hw_q[rd_q + PW'(i)];
  end
  assign mem_req_o = req_q;
  assign mem_addr_o = addr_q;
  assign pc_o = pc_q;
  assign avail_o = avail;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      pc_q <= RESET_PC;
      fa_q <= RESET_PC;
      odd_q <= RESET_PC[0];
      addr_q <= '0;
      req_q <= 1'b0;
      out_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      rd_q <= redirect_i ? '0 : rd_q + PW'(nr);
      wr_q <= redirect_i ? '0 : wr_q + PW'(wn);
      cnt_q <= cnt_n;
      pc_q <= redirect_i ? redirect_pc_i : pc_q + AW'(n);
      fa_q <= fa_n;
      odd_q <= redirect_i ? redirect_pc_i[0] : (acc ? 1'b0 : odd_q);
      if (issue) addr_q <= {fa_n[AW-1:1], 1'b0};
      req_q <= (req_q & ~mem_gnt_i) | issue;
      out_q <= (req_q & mem_gnt_i) | (out_q & ~mem_rvalid_i);
      // a redirect orphans whatever is in flight, whether still pending or already granted
      drop_q <= redirect_i ? inflight_n : (mem_rvalid_i ? 1'b0 : drop_q);
    end
  always_ff @(posedge clk)
    if (wn != 3'd0) begin
      hw_q[wr_q] <= nb[0] ? hw_hi : hw_lo;
      if (wn == 3'd2) hw_q[wr_q + PW'(1)] <= hw_hi;
    end
endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// tb_ifetch_prefetch_queue: directed checks of the prefetch queue against a zero-wait memory model.
module tb_ifetch_prefetch_queue;
  logic clk = 0, rst = 1;
  logic mem_req_o, mem_gnt_i, mem_rvalid_i;
  logic [24:0] mem_addr_o, pc_o, redirect_pc_i, paddr;
  logic [31:0] mem_rdata_i;
  logic [63:0] inst_o;
  logic [2:0] avail_o, consume_i;
  logic redirect_i, pend, hold_rv;
  logic [24:0] req_log[$];
  int n_cmp = 0, n_err = 0;
  ifetch_prefetch_queue #(.DEPTH(8), .AW(25), .RESET_PC(25'd0)) dut (
    .clk(clk), .rst(rst), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .inst_o(inst_o), .pc_o(pc_o), .avail_o(avail_o), .consume_i(consume_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i));
  always #5 clk = ~clk;
  function automatic logic [15:0] hw(input logic [24:0] a);
    return a[15:0] * 16'd3 + 16'h1234;
  endfunction
  function automatic logic [63:0] lanes(input logic [24:0] p, input int k);
    logic [63:0] r = '0;
    for (int i = 0; i < k; i++) r[16*i +: 16] = hw(p + 25'(i));
    return r;
  endfunction
  assign mem_gnt_i = mem_req_o;
  assign mem_rvalid_i = pend & ~hold_rv;
  assign mem_rdata_i = {hw(paddr + 25'd1), hw(paddr)};
  always @(posedge clk)
    if (rst) pend <= 1'b0;
    else if (mem_req_o && mem_gnt_i) begin
      pend <= 1'b1;
      paddr <= mem_addr_o;
      req_log.push_back(mem_addr_o);
    end else if (mem_rvalid_i) pend <= 1'b0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic redirect(input logic [24:0] p);
    redirect_i = 1'b1;
    redirect_pc_i = p;
    cyc(1);
    redirect_i = 1'b0;
  endtask
  initial begin
    consume_i = 0; redirect_i = 0; redirect_pc_i = 0; hold_rv = 0; paddr = 0;
    cyc(2);
    chk("rst_req", mem_req_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_avail", avail_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_pc", pc_o, 0);
    rst = 0;
    cyc(12);
    chk("fill_nreq", req_log.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("fill_addr%0d", k), req_log.size() > k ? req_log[k] : 25'h1ffffff, 25'(2 * k));
    chk("fill_req", mem_req_o, 0);
    chk("fill_avail", avail_o, 4);
    chk("fill_inst", inst_o, lanes(0, 4));
    consume_i = 1;
    cyc(1);
    consume_i = 0;
    chk("c1_pc", pc_o, 1);
    chk("c1_avail", avail_o, 4);
    chk("c1_inst", inst_o, lanes(1, 4));
    cyc(3);
    chk("c1_noreq", mem_req_o, 0);
    chk("c1_nreq", req_log.size(), 4);
    consume_i = 1;
    cyc(1);
    consume_i = 0;
    chk("c2_req", mem_req_o, 1);
    chk("c2_addr", mem_addr_o, 8);
    chk("c2_pc", pc_o, 2);
    cyc(4);
    redirect(25'h00005);
    chk("odd_req", mem_req_o, 1);
    chk("odd_addr", mem_addr_o, 4);
    chk("odd_pc", pc_o, 5);
    chk("odd_avail0", avail_o, 0);
    cyc(2);
    chk("odd_avail1", avail_o, 1);
    chk("odd_inst1", inst_o, lanes(5, 1));
    cyc(2);
    chk("odd_avail3", avail_o, 3);
    chk("odd_inst3", inst_o, lanes(5, 3));
    cyc(10);
    hold_rv = 1;
    redirect(25'h00100);
    chk("r1_addr", mem_addr_o, 25'h100);
    cyc(1);
    redirect(25'h00200);
    chk("r2_req", mem_req_o, 0);
    chk("r2_pc", pc_o, 25'h200);
    chk("r2_avail", avail_o, 0);
    cyc(2);
    chk("r2_hold", mem_req_o, 0);
    hold_rv = 0;
    cyc(1);
    chk("drop_avail", avail_o, 0);
    chk("drop_req", mem_req_o, 1);
    chk("drop_addr", mem_addr_o, 25'h200);
    cyc(2);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("st%0d_pc", k), pc_o, 25'h200 + 25'(2 * ((k + 1) / 2)));
      chk($sformatf("st%0d_avail", k), avail_o, (k % 2 == 0) ? 3'd2 : 3'd0);
      chk($sformatf("st%0d_inst", k), inst_o, (k % 2 == 0) ? lanes(pc_o, 2) : 64'd0);
      consume_i = 2;
      cyc(1);
    end
    chk("clamp_pre_avail", avail_o, 2);
    chk("clamp_pre_pc", pc_o, 25'h20a);
    consume_i = 4;
    cyc(1);
    consume_i = 0;
    chk("clamp_pc", pc_o, 25'h20c);
    chk("clamp_avail", avail_o, 0);
    cyc(14);
    chk("refill_avail", avail_o, 4);
    chk("refill_pc", pc_o, 25'h20c);
    chk("refill_inst", inst_o, lanes(25'h20c, 4));
    chk("refill_req", mem_req_o, 0);
    redirect(25'h1ffffff);
    chk("wrap_addr", mem_addr_o, 25'h1fffffe);
    cyc(12);
    chk("wrap_avail", avail_o, 4);
    chk("wrap_inst", inst_o, lanes(25'h1ffffff, 4));
    consume_i = 2;
    cyc(1);
    consume_i = 0;
    chk("wrap_pc", pc_o, 1);
    chk("wrap_inst2", inst_o, lanes(1, 4));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
